// File: rtl/sign_arbiter_pkg.sv
// sign_arbiter_pkg: shared widths, FSM states, +1/-1 sign codes and channel-index width helper
package sign_arbiter_pkg;
  localparam int R = 14;
  localparam int N = 4;
  function automatic int chw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  localparam int CW = chw(N);
  typedef enum logic [1:0] {IDLE, CAPT, RESULT} state_t;
  localparam logic signed [R-1:0] SPOS = R'(1);
  localparam logic signed [R-1:0] SNEG = '1;
  localparam logic signed [1:0] S2POS = 2'b01;
  localparam logic signed [1:0] S2NEG = 2'b11;
endpackage

// File: rtl/sign_arbiter_if.sv
// sign_arbiter_if: requester bus (req/din in; ack, sign_out, sign2, out_ch, out_valid, out_flip, busy out)
interface sign_arbiter_if;
  import sign_arbiter_pkg::*;
  logic [N-1:0] req;
  logic [N*R-1:0] din;
  logic [N-1:0] ack;
  logic signed [R-1:0] sign_out;
  logic signed [1:0] sign2;
  logic [CW-1:0] out_ch;
  logic out_valid;
  logic out_flip;
  logic busy;
  modport master (output req, din, input ack, sign_out, sign2, out_ch, out_valid, out_flip, busy);
  modport slave (input req, din, output ack, sign_out, sign2, out_ch, out_valid, out_flip, busy);
endinterface

// File: rtl/sign_arbiter_rr_pick.sv
// sign_arbiter_rr_pick: combinational round-robin pick (req, mask, ptr in; win, any out), first eligible from ptr wins
module sign_arbiter_rr_pick import sign_arbiter_pkg::*; (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [CW-1:0] ptr,
  output logic [CW-1:0] win,
  output logic          any
);
  logic [N-1:0] el;
  assign el = req & mask;
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (el[CW'((int'(ptr) + k) % N)]) begin
        win = CW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sign_arbiter.sv
// sign_arbiter: round-robin shared sign unit (clk, rstn, bus slave: req/din in, registered ack/sign/channel/flip/busy out)
module sign_arbiter import sign_arbiter_pkg::*; (
  input logic           clk,
  input logic           rstn,
  sign_arbiter_if.slave bus
);
  localparam logic signed [R-1:0] ZERO = '0;
  state_t state;
  logic [CW-1:0] rr_ptr, g, win;
  logic signed [R-1:0] smp;
  logic [N-1:0] last_neg, mask;
  logic [R-1:0] dv [N];
  logic any, neg;
  for (genvar i = 0; i < N; i++) begin : g_slice
    assign dv[i] = bus.din[i*R +: R];
  end
  assign mask = (state == RESULT) ? ~(N'(1) << g) : '1;
  assign neg = smp < ZERO;
  sign_arbiter_rr_pick u_pick (.req(bus.req), .mask(mask), .ptr(rr_ptr), .win(win), .any(any));
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      rr_ptr <= '0;
      g <= '0;
      smp <= '0;
      last_neg <= '0;
      bus.ack <= '0;
      bus.sign_out <= SPOS;
      bus.sign2 <= S2POS;
      bus.out_ch <= '0;
      bus.out_valid <= 1'b0;
      bus.out_flip <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.ack <= '0;
      bus.out_valid <= 1'b0;
      if (state == CAPT) begin
        bus.sign_out <= neg ? SNEG : SPOS;
        bus.sign2 <= neg ? S2NEG : S2POS;
        bus.out_ch <= g;
        bus.out_flip <= neg != last_neg[g];
        last_neg[g] <= neg;
        bus.ack <= N'(1) << g;
        bus.out_valid <= 1'b1;
        state <= RESULT;
      end else if (any) begin
        g <= win;
        smp <= dv[win];
        rr_ptr <= (win == CW'(N - 1)) ? '0 : win + 1'b1;
        state <= CAPT;
        bus.busy <= 1'b1;
      end else begin
        state <= IDLE;
        bus.busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sign_arbiter.sv
// tb_sign_arbiter: directed self-checking bench for sign_arbiter
module tb_sign_arbiter;
  import sign_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rstn;
  int errs = 0;
  int checks = 0;
  sign_arbiter_if bus();
  sign_arbiter dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.req = '0;
    bus.din = '0;
    repeat (2) tick();
    checks++; if (bus.ack !== 4'b0000) begin errs++; $display("FAIL reset_ack got=%b exp=0000", bus.ack); end
    checks++; if (bus.sign_out !== 14'h0001) begin errs++; $display("FAIL reset_sign_out got=%h exp=0001", bus.sign_out); end
    checks++; if (bus.sign2 !== 2'b01) begin errs++; $display("FAIL reset_sign2 got=%b exp=01", bus.sign2); end
    checks++; if (bus.out_ch !== 2'd0) begin errs++; $display("FAIL reset_out_ch got=%0d exp=0", bus.out_ch); end
    checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_flip !== 1'b0) begin errs++; $display("FAIL reset_out_flip got=%b exp=0", bus.out_flip); end
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    rstn = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_single();
    bus.din[2*R +: R] = 14'h3FFB;
    bus.req = 4'b0100;
    tick();
    checks++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL single_capt_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL single_capt_valid got=%b exp=0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.ack !== 4'b0100) begin errs++; $display("FAIL single_ack got=%b exp=0100", bus.ack); end
    checks++; if (bus.out_ch !== 2'd2) begin errs++; $display("FAIL single_out_ch got=%0d exp=2", bus.out_ch); end
    checks++; if (bus.sign_out !== 14'h3FFF) begin errs++; $display("FAIL single_sign_out got=%h exp=3fff", bus.sign_out); end
    checks++; if (bus.sign2 !== 2'b11) begin errs++; $display("FAIL single_sign2 got=%b exp=11", bus.sign2); end
    checks++; if (bus.out_flip !== 1'b1) begin errs++; $display("FAIL single_flip got=%b exp=1", bus.out_flip); end
    bus.req = '0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin errs++; $display("FAIL single_pulse got=%b/%b exp=0/0000", bus.out_valid, bus.ack); end
    checks++; if (bus.sign_out !== 14'h3FFF) begin errs++; $display("FAIL single_hold got=%h exp=3fff", bus.sign_out); end
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL single_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_boundaries();
    logic [R-1:0] v [3] = '{14'h0000, 14'h2000, 14'h1FFF};
    logic [R-1:0] es [3] = '{14'h0001, 14'h3FFF, 14'h0001};
    logic [1:0] e2 [3] = '{2'b01, 2'b11, 2'b01};
    logic ef [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      bus.din[0 +: R] = v[i];
      bus.req = 4'b0001;
      tick();
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0) begin errs++; $display("FAIL bound%0d_valid_ch got=%b/%0d exp=1/0", i, bus.out_valid, bus.out_ch); end
      checks++; if (bus.sign_out !== es[i]) begin errs++; $display("FAIL bound%0d_sign_out got=%h exp=%h", i, bus.sign_out, es[i]); end
      checks++; if (bus.sign2 !== e2[i]) begin errs++; $display("FAIL bound%0d_sign2 got=%b exp=%b", i, bus.sign2, e2[i]); end
      checks++; if (bus.out_flip !== ef[i]) begin errs++; $display("FAIL bound%0d_flip got=%b exp=%b", i, bus.out_flip, ef[i]); end
      bus.req = '0;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e2 [4] = '{2'b01, 2'b11, 2'b01, 2'b11};
    int ch;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    bus.din = {14'h2000, 14'h0001, 14'h3F9C, 14'h0064};
    bus.req = 4'b1111;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c % 2 == 0) begin
        ch = (c / 2 - 1) % 4;
        checks++; if (bus.out_valid !== 1'b1 || bus.ack !== 4'(1 << ch)) begin errs++; $display("FAIL b2b_c%0d_ack got=%b/%b exp=1/%b", c, bus.out_valid, bus.ack, 4'(1 << ch)); end
        checks++; if (bus.out_ch !== 2'(ch) || bus.sign2 !== e2[ch]) begin errs++; $display("FAIL b2b_c%0d_ch_sign got=%0d/%b exp=%0d/%b", c, bus.out_ch, bus.sign2, ch, e2[ch]); end
        checks++; if (bus.out_flip !== (c <= 8 && ch % 2 == 1)) begin errs++; $display("FAIL b2b_c%0d_flip got=%b exp=%b", c, bus.out_flip, c <= 8 && ch % 2 == 1); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000 || bus.busy !== 1'b1) begin errs++; $display("FAIL b2b_c%0d_gap got=%b/%b/%b exp=0/0000/1", c, bus.out_valid, bus.ack, bus.busy); end
      end
    end
    bus.req = '0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL b2b_end_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_wrap_mask();
    int ch;
    bus.req = 4'b0100;
    tick();
    tick();
    checks++; if (bus.out_ch !== 2'd2 || bus.out_valid !== 1'b1) begin errs++; $display("FAIL wrap_pre_ch got=%0d/%b exp=2/1", bus.out_ch, bus.out_valid); end
    bus.req = '0;
    tick();
    bus.din[0 +: R] = 14'h2000;
    bus.req = 4'b1001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c % 2 == 0) begin
        ch = ((c / 2) % 2 == 1) ? 3 : 0;
        checks++; if (bus.out_valid !== 1'b1 || bus.ack !== 4'(1 << ch) || bus.out_ch !== 2'(ch)) begin errs++; $display("FAIL wrap_c%0d got=%b/%b/%0d exp=1/%b/%0d", c, bus.out_valid, bus.ack, bus.out_ch, 4'(1 << ch), ch); end
        checks++; if (bus.sign2 !== 2'b11) begin errs++; $display("FAIL wrap_c%0d_sign2 got=%b exp=11", c, bus.sign2); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL wrap_c%0d_gap got=%b exp=0", c, bus.out_valid); end
      end
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.din[1*R +: R] = 14'h3FF9;
    bus.req = 4'b0010;
    tick();
    checks++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL mid_capt_busy got=%b exp=1", bus.busy); end
    rstn = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin errs++; $display("FAIL mid_rst_ctl got=%b/%b/%b exp=0/0/0000", bus.busy, bus.out_valid, bus.ack); end
    checks++; if (bus.sign_out !== 14'h0001 || bus.sign2 !== 2'b01) begin errs++; $display("FAIL mid_rst_sign got=%h/%b exp=0001/01", bus.sign_out, bus.sign2); end
    checks++; if (bus.out_ch !== 2'd0 || bus.out_flip !== 1'b0) begin errs++; $display("FAIL mid_rst_ch_flip got=%0d/%b exp=0/0", bus.out_ch, bus.out_flip); end
    bus.req = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (bus.ack !== 4'b0000 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL mid_no_ack%0d got=%b/%b exp=0000/0", c, bus.ack, bus.out_valid); end
    end
    rstn = 1'b1;
    tick();
    bus.din[1*R +: R] = 14'd50;
    bus.req = 4'b0010;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1 || bus.sign_out !== 14'h0001) begin errs++; $display("FAIL mid_after got=%b/%0d/%h exp=1/1/0001", bus.out_valid, bus.out_ch, bus.sign_out); end
    checks++; if (bus.out_flip !== 1'b0) begin errs++; $display("FAIL mid_after_flip got=%b exp=0", bus.out_flip); end
    bus.req = '0;
    tick();
  endtask

  task automatic test_early_drop();
    bus.din[1*R +: R] = 14'h3FFD;
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.ack !== 4'b0010) begin errs++; $display("FAIL drop_ack got=%b/%b exp=1/0010", bus.out_valid, bus.ack); end
    checks++; if (bus.sign_out !== 14'h3FFF || bus.out_flip !== 1'b1) begin errs++; $display("FAIL drop_sign got=%h/%b exp=3fff/1", bus.sign_out, bus.out_flip); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin errs++; $display("FAIL drop_idle got=%b/%b/%b exp=0/0/0000", bus.busy, bus.out_valid, bus.ack); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL drop_stay_idle got=%b/%b exp=0/0", bus.busy, bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_back_to_back();
    test_wrap_mask();
    test_reset_mid();
    test_early_drop();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
